// File: rtl/ofm_axis_stream_sender.sv
`default_nettype none
// ============================================================================
//  Module      : ofm_axis_stream_sender
//  Description : Streams a finished OFM tile out of the OFM buffer read port
//                onto an AXI-Stream master for DMA write-back. The inclusive
//                address range [addr_start, addr_end] is read in ascending
//                order and tlast marks the final beat. A small output FIFO,
//                guarded by a read-credit check, absorbs the buffer's fixed
//                read latency so that backpressure never drops or duplicates
//                a beat.
//
//  Ports
//    clk            in   1         single clock, rising-edge logic
//    rst            in   1         asynchronous, active-low reset
//    send_enable    in   1         level; a sampled 0->1 edge starts a transfer
//    addr_start     in   ADDR_BIT  first address, latched at start
//    addr_end       in   ADDR_BIT  last address (inclusive), latched at start
//    send_running   out  1         high from start until send_done
//    send_done      out  1         one-cycle pulse when the transfer completes
//    read_en        out  1         OFM buffer read strobe
//    read_addr      out  ADDR_BIT  OFM buffer read address
//    read_data      in   DATA_BIT  buffer data, READ_LATENCY cycles after read_en
//    m_axis_tvalid  out  1         AXIS valid
//    m_axis_tdata   out  DATA_BIT  AXIS data
//    m_axis_tlast   out  1         AXIS last, high only on the final beat
//    m_axis_tready  in   1         AXIS ready
//
//  Revision    : 1.0 - initial release
// ============================================================================
module ofm_axis_stream_sender #(
  parameter int ADDR_BIT     = 16,
  parameter int DATA_BIT     = 64,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                send_enable,
  input  logic [ADDR_BIT-1:0] addr_start,
  input  logic [ADDR_BIT-1:0] addr_end,
  output logic                send_running,
  output logic                send_done,
  output logic                read_en,
  output logic [ADDR_BIT-1:0] read_addr,
  input  logic [DATA_BIT-1:0] read_data,
  output logic                m_axis_tvalid,
  output logic [DATA_BIT-1:0] m_axis_tdata,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // FIFO count plus in-flight reads can exceed FIFO_DEPTH transiently in
  // arithmetic, so the occupancy sum gets one extra bit.
  localparam int OCC_W = CNT_W + 1;

  localparam logic [OCC_W-1:0] DEPTH_LIMIT = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (FIFO_DEPTH < READ_LATENCY + 2) begin : g_depth_check
      $error("FIFO_DEPTH must be at least READ_LATENCY+2");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_latency_check
      $error("READ_LATENCY must be 1 or 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]          state;
  logic                en_q;          // send_enable seen at the previous edge
  logic                start_q;       // start request accepted, FSM acts next
  logic                start_edge;
  logic                range_empty;
  logic [ADDR_BIT-1:0] end_addr;
  logic [ADDR_BIT-1:0] addr_cur;
  logic                issue_last;

  // Read-return tracking: bit i is set while a read is i+1 cycles old.
  logic [READ_LATENCY-1:0] rd_vld;
  logic [READ_LATENCY-1:0] rd_last;
  logic                    push;
  logic                    push_last;
  logic                    pop;

  logic [DATA_BIT-1:0] fifo_data [FIFO_DEPTH];
  logic                fifo_last [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    fifo_count;

  logic [OCC_W-1:0]    inflight;
  logic [OCC_W-1:0]    occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // --------------------------------------------------------------------------
  // Start detection and range latching
  // --------------------------------------------------------------------------
  // A rise is honoured only from IDLE with no start already pending, so edges
  // during a transfer or in the DONE cycle are dropped.
  assign start_edge = send_enable & ~en_q & ~start_q & (state == ST_IDLE);
  assign issue_last = (addr_cur == end_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q        <= 1'b0;
      start_q     <= 1'b0;
      range_empty <= 1'b0;
      end_addr    <= '0;
      addr_cur    <= '0;
    end else begin
      en_q    <= send_enable;
      start_q <= start_edge;
      if (start_edge) begin
        addr_cur    <= addr_start;
        end_addr    <= addr_end;
        range_empty <= (addr_end < addr_start);
      end else if (read_en && !issue_last) begin
        // Stop on the final address instead of incrementing, so an end of
        // all-ones never wraps to zero.
        addr_cur <= addr_cur + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  // An empty range has nothing to fetch; it passes through DRAIN for one
  // cycle with no outstanding data, which places send_done two cycles after
  // the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_q) begin
            state <= range_empty ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (read_en && issue_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (range_empty || (pop && m_axis_tlast)) begin
            state <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign send_running = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign send_done    = (state == ST_DONE);

  // --------------------------------------------------------------------------
  // Read credit
  // --------------------------------------------------------------------------
  // Every read still in the buffer pipeline already owns a FIFO slot, so a
  // new read is allowed only while pipeline + FIFO leaves one slot free.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(rd_vld[i]);
    end
  end

  assign occupancy = inflight + OCC_W'(fifo_count);
  assign read_en   = (state == ST_ISSUE) && (occupancy < DEPTH_LIMIT);
  assign read_addr = addr_cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_vld  <= '0;
      rd_last <= '0;
    end else begin
      rd_vld[0]  <= read_en;
      rd_last[0] <= read_en & issue_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_vld[i]  <= rd_vld[i-1];
        rd_last[i] <= rd_last[i-1];
      end
    end
  end

  // The oldest stage lines up with read_data on the buffer port.
  assign push      = rd_vld[READ_LATENCY-1];
  assign push_last = rd_last[READ_LATENCY-1];

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  assign pop = m_axis_tvalid & m_axis_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= read_data;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Push and pop together (including on a full FIFO) leave the count
      // unchanged.
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head entry drives the bus directly; it cannot change until popped, so
  // data and last stay stable while the sink stalls.
  assign m_axis_tvalid = (fifo_count != '0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = fifo_last[rd_ptr] & m_axis_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_ofm_axis_stream_sender.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ofm_axis_stream_sender
//  Description : Scoreboard bench for ofm_axis_stream_sender. Each started
//                transfer pushes its expected beats into a queue; a monitor
//                pops and compares on every AXIS handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ofm_axis_stream_sender;

  localparam logic [63:0] PAT = 64'h0101010101010101;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        send_enable = 1'b0;
  logic [15:0] addr_start = '0;
  logic [15:0] addr_end = '0;
  logic        send_running;
  logic        send_done;
  logic        read_en;
  logic [15:0] read_addr;
  logic [63:0] read_data = '0;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;

  ofm_axis_stream_sender #(
    .ADDR_BIT(16), .DATA_BIT(64), .READ_LATENCY(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .send_enable(send_enable),
    .addr_start(addr_start), .addr_end(addr_end),
    .send_running(send_running), .send_done(send_done),
    .read_en(read_en), .read_addr(read_addr), .read_data(read_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pattern(input logic [15:0] a);
    return {48'd0, a} * PAT;
  endfunction

  // OFM buffer model, one cycle read latency
  always @(posedge clk) begin
    if (read_en) read_data <= pattern(read_addr);
  end

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // tready driver: 0 = always ready, 1 = random 50%, 2 = stalled
  int rdy_mode = 2;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  int issued = 0, popped = 0, max_occ = 0;
  int beats = 0, done_count = 0, cyc = 0, first_hs = -1, last_hs = -1;
  int lo = 0, hi = -1;
  logic        stall_q = 1'b0;
  logic [63:0] stall_d = '0;
  logic        stall_l = 1'b0;
  logic        want_done = 1'b0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst) begin
      stall_q = 1'b0; want_done = 1'b0; issued = 0; popped = 0;
    end else begin
      int    occ;
      beat_t e;
      if (want_done) begin
        check("done_after_tlast", {63'd0, send_done}, 64'd1);
        check("running_low_at_done", {63'd0, send_running}, 64'd0);
        want_done = 1'b0;
      end
      if (stall_q) begin
        check("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        check("hold_tdata", m_axis_tdata, stall_d);
        check("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, stall_l});
      end
      if (send_done) done_count++;
      if (read_en)
        check("read_addr_in_range",
              {63'd0, (int'(read_addr) >= lo) && (int'(read_addr) <= hi)}, 64'd1);
      occ = issued + int'(read_en) - popped;
      if (occ > max_occ) max_occ = occ;
      issued += int'(read_en);
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_axis_tdata, e.data);
          check("tlast", {63'd0, m_axis_tlast}, {63'd0, e.last});
        end
        popped++; beats++;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (m_axis_tlast) want_done = 1'b1;
      end
      stall_q = m_axis_tvalid && !m_axis_tready;
      stall_d = m_axis_tdata;
      stall_l = m_axis_tlast;
    end
  end

  // Returns just after the edge that samples the send_enable rise
  task automatic start_xfer(input int s, input int e);
    if (send_enable) begin
      send_enable = 1'b0;
      @(posedge clk); #1;
    end
    for (int a = s; a <= e; a++) exp_q.push_back('{data: pattern(16'(a)), last: (a == e)});
    lo = s; hi = e;
    beats = 0; first_hs = -1; last_hs = -1;
    addr_start = 16'(s); addr_end = 16'(e);
    send_enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_count == base && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check(name, 64'(done_count - base), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_single"}, 64'(done_count - base), 64'd1);
  endtask

  initial begin
    int base, k, snap;
    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
    check("rst_read_en", {63'd0, read_en}, 64'd0);
    check("rst_read_addr", {48'd0, read_addr}, 64'd0);
    check("rst_running", {63'd0, send_running}, 64'd0);
    check("rst_done", {63'd0, send_done}, 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---------------- 1: 0..7, always ready ----------------
    rdy_mode = 0;
    base = done_count;
    start_xfer(0, 7);
    k = 0;
    while (!m_axis_tvalid && k < 10) begin
      @(posedge clk); #1; k++;
    end
    check("t1_first_tvalid_latency", 64'(k), 64'd3);
    check("t1_running", {63'd0, send_running}, 64'd1);
    send_enable = 1'b0;  // dropping mid-transfer must not abort
    wait_done(base, 100, "t1_done");
    check("t1_beats", 64'(beats), 64'd8);
    check("t1_back_to_back", 64'(last_hs - first_hs), 64'd7);
    check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- 2: 0..31, random ready + stall ----------------
    rdy_mode = 1;
    max_occ = 0;
    base = done_count;
    start_xfer(0, 31);
    repeat (8) @(posedge clk);
    #1;
    rdy_mode = 2;
    repeat (20) @(posedge clk);
    #1;
    rdy_mode = 1;
    wait_done(base, 600, "t2_done");
    check("t2_beats", 64'(beats), 64'd32);
    check("t2_queue_empty", 64'(exp_q.size()), 64'd0);
    check("t2_max_outstanding", 64'(max_occ), 64'd4);

    // ---------------- 3: single beat ----------------
    rdy_mode = 0;
    base = done_count;
    start_xfer(5, 5);
    wait_done(base, 50, "t3_done");
    check("t3_beats", 64'(beats), 64'd1);

    // ---------------- 4: empty range ----------------
    base = done_count;
    start_xfer(10, 9);
    @(posedge clk); #1;
    check("t4_done_k1", {63'd0, send_done}, 64'd0);
    check("t4_tvalid_k1", {63'd0, m_axis_tvalid}, 64'd0);
    @(posedge clk); #1;
    check("t4_done_k2", {63'd0, send_done}, 64'd1);
    check("t4_tvalid_k2", {63'd0, m_axis_tvalid}, 64'd0);
    @(posedge clk); #1;
    check("t4_done_k3", {63'd0, send_done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_done_count", 64'(done_count - base), 64'd1);
    check("t4_beats", 64'(beats), 64'd0);

    // ---------------- 5: reset mid-transfer, then full run ----------------
    base = done_count;
    start_xfer(0, 15);
    k = 0;
    while (beats < 3 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("t5_three_beats_seen", {63'd0, beats >= 3}, 64'd1);
    rst = 1'b0;
    #1;
    check("t5_abort_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
    check("t5_abort_read_en", {63'd0, read_en}, 64'd0);
    check("t5_abort_running", {63'd0, send_running}, 64'd0);
    exp_q.delete();
    send_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    start_xfer(0, 15);
    wait_done(base, 100, "t5_done");
    check("t5_beats", 64'(beats), 64'd16);
    check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- 6: top of address space, enable held ----------------
    base = done_count;
    start_xfer(16'hFFFC, 16'hFFFF);
    wait_done(base, 50, "t6_done");
    check("t6_beats", 64'(beats), 64'd4);
    snap = issued;
    base = done_count;
    repeat (10) @(posedge clk);
    #1;
    check("t6_no_restart_reads", 64'(issued - snap), 64'd0);
    check("t6_no_restart_done", 64'(done_count - base), 64'd0);
    check("t6_no_restart_running", {63'd0, send_running}, 64'd0);
    start_xfer(16'hFFFC, 16'hFFFF);  // toggles low then high
    wait_done(base, 50, "t6_retoggle_done");
    check("t6_retoggle_beats", 64'(beats), 64'd4);
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
